tv80_mem_arbiter: RTL and testbench

Round-robin arbiter that lets up to `NCPU` tv80_core instances share one external memory port. Each core's bus cycle becomes a request. The arbiter serialises the requests onto a single memory handshake and holds each non-served core in wait state through its `wait_n` input. It sits between the tv80_core instances in the multi-core top level and the board memory controller.

---
 rtl/tv80_arb_pkg.sv | 17 +
 rtl/tv80_rr_pick.sv | 30 +++
 rtl/tv80_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_tv80_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tv80_arb_pkg.sv
// Shared types and defaults for the tv80 memory arbiter family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tv80_arb_pkg;

    // Arbiter phases: IDLE picks a winner, BUS runs the memory handshake,
    // DONE pulses ack back to the served core.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    localparam int ARB_AW_DEF = 16;
    localparam int ARB_DW_DEF = 8;

endpackage

// File: rtl/tv80_rr_pick.sv
// Round-robin one-hot picker: lowest set request at or above ptr, with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on pick.
//
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - index with highest priority this round (must be < N)
//   pick - one-hot winner, all zero when req is zero
module tv80_rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_first;

    // Rotate requests right by ptr so the priority position lands on bit 0.
    assign w_rot   = N'({req, req} >> ptr);

    // Two's-complement trick isolates the lowest set bit.
    assign w_first = w_rot & (-w_rot);

    // Rotate the winner back left by ptr into original core numbering.
    assign pick    = N'(({w_first, w_first} << ptr) >> N);

endmodule

// File: rtl/tv80_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NCPU tv80 cores.
// Latency: req sampled at edge k -> mem_req in k+1, ack in k+2 plus memory wait cycles.
// Backpressure: losers and the core in flight are stalled via wait_n; memory stalls via mem_ack.
//
// Ports:
//   clk, reset           - shared clock, asynchronous active-high reset
//   req/wr/addr/wdata    - per-core bus cycle (level request, held until ack)
//   wait_n/ack/rdata     - per-core stall, one-cycle completion, read data
//   grant                - one-hot core in service, zero when idle
//   mem_req/we/addr/wdata, mem_rdata/mem_ack - single memory handshake
module tv80_mem_arbiter
    import tv80_arb_pkg::*;
#(
    parameter int NCPU = 4,
    parameter int AW   = ARB_AW_DEF,
    parameter int DW   = ARB_DW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCPU-1:0]      req,
    input  logic [NCPU-1:0]      wr,
    input  logic [NCPU*AW-1:0]   addr,
    input  logic [NCPU*DW-1:0]   wdata,
    output logic [NCPU-1:0]      wait_n,
    output logic [NCPU-1:0]      ack,
    output logic [DW-1:0]        rdata,
    output logic [NCPU-1:0]      grant,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    input  logic                 mem_ack
);

    localparam int PW = (NCPU > 1) ? $clog2(NCPU) : 1;

    arb_state_t      r_state;
    arb_state_t      w_next;
    logic [PW-1:0]   r_ptr;
    logic [NCPU-1:0] r_grant;
    logic [DW-1:0]   r_rdata;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;

    logic [NCPU-1:0] w_pick;
    logic            w_load;
    logic            w_bus_end;
    logic            w_done;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_sel_we;
    logic [PW-1:0]   w_gidx;
    logic [PW-1:0]   w_ptr_next;

    tv80_rr_pick #(
        .N  (NCPU),
        .PW (PW)
    ) u_pick (
        .req  (req),
        .ptr  (r_ptr),
        .pick (w_pick)
    );

    // Winner's bus cycle, selected by the one-hot pick.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NCPU; i++) begin
            if (w_pick[i]) begin
                w_sel_addr  = addr[i*AW +: AW];
                w_sel_wdata = wdata[i*DW +: DW];
                w_sel_we    = wr[i];
            end
        end
    end

    // Index of the core in service; the next round starts just past it.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NCPU; i++) begin
            if (r_grant[i]) begin
                w_gidx = PW'(i);
            end
        end
        w_ptr_next = (int'(w_gidx) == NCPU - 1) ? '0 : w_gidx + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_bus_end = 1'b0;
        w_done    = 1'b0;
        ack       = '0;
        case (r_state)
            ARB_IDLE: begin
                if (|req) begin
                    w_load = 1'b1;
                    w_next = ARB_BUS;
                end
            end
            ARB_BUS: begin
                if (mem_ack) begin
                    w_bus_end = 1'b1;
                    w_next    = ARB_DONE;
                end
            end
            ARB_DONE: begin
                // Requests still high here are only looked at again from IDLE.
                w_done = 1'b1;
                ack    = r_grant;
                w_next = ARB_IDLE;
            end
            default: begin
                w_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_grant     <= '0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_load) begin
                r_grant     <= w_pick;
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_sel_we;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
            end
            if (w_bus_end) begin
                r_mem_req <= 1'b0;
                if (!r_mem_we) begin
                    r_rdata <= mem_rdata;
                end
            end
            if (w_done) begin
                r_ptr   <= w_ptr_next;
                r_grant <= '0;
            end
        end
    end

    // A core runs freely when it is not asking, or in its completion cycle.
    assign wait_n    = ~req | ack;
    assign grant     = r_grant;
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_tv80_mem_arbiter.sv
`timescale 1ns/1ps
module tb_tv80_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, wr;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    wait_n, ack, grant;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic            mem_req, mem_we, mem_ack;
    logic [AW-1:0]   mem_addr;

    tv80_mem_arbiter #(.NCPU(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .wait_n(wait_n), .ack(ack), .rdata(rdata), .grant(grant),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Transaction-level reference: one scheduled transaction at a time.
    int          cyc = 0;
    int          lat_fix = 0;
    int          m_ptr, m_free, m_t, m_ack_cyc, m_w, m_lat;
    bit          m_act;
    logic [15:0] m_addr;
    logic        m_we;
    logic [7:0]  m_wd, m_rdata;
    logic [N-1:0] hold = '0;
    logic        exp_mem_req;
    logic [N-1:0] exp_grant, exp_ack, exp_wait_n;

    function automatic logic [7:0] rdfn(input logic [15:0] a);
        if (a == 16'h1234) return 8'h5A;
        return a[7:0] ^ a[15:8] ^ 8'h96;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_free = 0; m_t = 0; m_ack_cyc = -100; m_w = 0; m_act = 0;
        m_addr = '0; m_we = 1'b0; m_wd = '0; m_rdata = '0;
    endtask

    // Called at each rising edge with the requests the DUT just sampled.
    task automatic model_edge();
        if (reset) return;
        if (m_act && cyc > m_ack_cyc) m_act = 0;
        if (!m_act && cyc >= m_free && req != '0) begin
            m_w = -1;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (m_w < 0 && req[i]) m_w = i;
            end
            m_lat     = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
            m_t       = cyc;
            m_ack_cyc = cyc + m_lat + 1;
            m_free    = m_ack_cyc + 2;
            m_act     = 1;
            m_addr    = addr[m_w*AW +: AW];
            m_we      = wr[m_w];
            m_wd      = wdata[m_w*DW +: DW];
            m_ptr     = (m_w + 1) % N;
        end
    endtask

    task automatic model_expect();
        exp_mem_req = m_act && (cyc < m_ack_cyc);
        exp_grant   = (m_act && cyc <= m_ack_cyc) ? N'(1 << m_w) : '0;
        exp_ack     = (m_act && cyc == m_ack_cyc) ? N'(1 << m_w) : '0;
        if (m_act && cyc == m_ack_cyc && !m_we) m_rdata = rdfn(m_addr);
        exp_wait_n  = ~req | exp_ack;
    endtask

    // One clock: model update at the edge, core/memory drive at +1, sample at negedge.
    task automatic step();
        bit bus;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        if (cyc == m_ack_cyc + 1 && !hold[m_w]) req[m_w] = 1'b0;
        bus = m_act && (cyc < m_ack_cyc);
        if (bus && cyc == m_ack_cyc - 1) begin
            mem_ack = 1'b1;
            mem_rdata = rdfn(m_addr);
        end else begin
            // Outside BUS the acknowledge is junk and must be ignored.
            mem_ack = bus ? 1'b0 : 1'($urandom_range(0, 1));
            mem_rdata = 8'($urandom);
        end
        @(negedge clk);
        model_expect();
    endtask

    task automatic do_reset();
        req = '0; hold = '0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req = 4'b0101;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (wait_n !== 4'b1010) begin n_fail++; $display("FAIL rst_wait_n got=%b exp=1010", wait_n); end
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant got=%b exp=0000", grant); end
        n_chk++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rst_ack got=%b exp=0000", ack); end
        n_chk++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
        n_chk++; if ({mem_we, mem_addr, mem_wdata} !== 25'd0) begin
            n_fail++; $display("FAIL rst_mem_bus got we=%b a=%h d=%h exp all zero", mem_we, mem_addr, mem_wdata);
        end
        req = '0;
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        lat_fix = 0;
        wr[0] = 1'b0; addr[0 +: AW] = 16'h1234; req[0] = 1'b1;
        #1;
        n_chk++; if (wait_n[0] !== 1'b0) begin n_fail++; $display("FAIL sr_wait_pre got=%b exp=0", wait_n[0]); end
        step();
        n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL sr_mem_req got=%b exp=1", mem_req); end
        n_chk++; if (mem_addr !== 16'h1234) begin n_fail++; $display("FAIL sr_mem_addr got=%h exp=1234", mem_addr); end
        n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL sr_mem_we got=%b exp=0", mem_we); end
        n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL sr_grant got=%b exp=0001", grant); end
        n_chk++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL sr_ack_early got=%b exp=0000", ack); end
        step();
        n_chk++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL sr_ack got=%b exp=0001", ack); end
        n_chk++; if (wait_n[0] !== 1'b1) begin n_fail++; $display("FAIL sr_wait_ack got=%b exp=1", wait_n[0]); end
        n_chk++; if (rdata !== 8'h5A) begin n_fail++; $display("FAIL sr_rdata got=%h exp=5a", rdata); end
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL sr_mem_req_done got=%b exp=0", mem_req); end
        step();
        n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL sr_grant_idle got=%b exp=0000", grant); end
    endtask

    task automatic test_all_four();
        logic [N-1:0] e;
        do_reset();
        lat_fix = 0;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW] = 16'(16'h1000 * (i + 1) + i);
            wr[i] = 1'b0;
        end
        req = 4'b1111;
        for (int j = 0; j < 12; j++) begin
            step();
            e = (j % 3 == 1) ? N'(1 << (j / 3)) : '0;
            n_chk++; if (ack !== e) begin n_fail++; $display("FAIL a4_ack j=%0d got=%b exp=%b", j, ack, e); end
            e = (j % 3 != 2) ? N'(1 << (j / 3)) : '0;
            n_chk++; if (grant !== e) begin n_fail++; $display("FAIL a4_grant j=%0d got=%b exp=%b", j, grant, e); end
            for (int i = 0; i < N; i++) e[i] = (j > 3 * i + 1) || (j == 3 * i + 1);
            n_chk++; if (wait_n !== e) begin n_fail++; $display("FAIL a4_wait_n j=%0d got=%b exp=%b", j, wait_n, e); end
            if (j % 3 == 0) begin
                n_chk++;
                if (mem_addr !== 16'(16'h1000 * (j / 3 + 1) + j / 3)) begin
                    n_fail++; $display("FAIL a4_mem_addr j=%0d got=%h", j, mem_addr);
                end
            end
        end
    endtask

    task automatic test_delayed_write();
        logic [7:0] r_before;
        r_before = m_rdata;
        lat_fix = 4;
        wr[2] = 1'b1; addr[2*AW +: AW] = 16'h8000; wdata[2*DW +: DW] = 8'hC3; req[2] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            n_chk++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h8000, 8'hC3}) begin
                n_fail++; $display("FAIL dw_bus j=%0d got req=%b we=%b a=%h d=%h exp 1 1 8000 c3", j, mem_req, mem_we, mem_addr, mem_wdata);
            end
            n_chk++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL dw_ack_early j=%0d got=%b", j, ack); end
            if (j == 0) begin addr[2*AW +: AW] = 16'h0000; wdata[2*DW +: DW] = 8'h00; end
            if (j == 2) req[2] = 1'b0;  // withdrawn mid-transaction
        end
        step();
        n_chk++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL dw_ack got=%b exp=0100", ack); end
        n_chk++; if (rdata !== r_before) begin n_fail++; $display("FAIL dw_rdata got=%h exp=%h", rdata, r_before); end
        step();
    endtask

    task automatic test_rr_hold();
        int q[$];
        do_reset();
        lat_fix = 0;
        wr[1] = 1'b0; wr[3] = 1'b0;
        hold[1] = 1'b1;
        req[1] = 1'b1; req[3] = 1'b1;
        for (int j = 0; j < 9; j++) begin
            step();
            if (mem_req === 1'b1) q.push_back(int'($clog2(grant)));
            n_chk++; if (ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack j=%0d got=%b exp=%b", j, ack, exp_ack); end
        end
        hold = '0; req = '0;
        n_chk++; if (q.size() != 3 || q[0] != 1 || q[1] != 3 || q[2] != 1) begin
            n_fail++; $display("FAIL rr_order got=%p exp='{1,3,1}", q);
        end
        step(); step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat_fix = 0;
        wr[1] = 1'b0; addr[1*AW +: AW] = 16'h0101; req[1] = 1'b1;
        step(); step(); step();
        hold[1] = 1'b1; hold[3] = 1'b1;
        req[1] = 1'b1; req[3] = 1'b1; wr[3] = 1'b0;
        lat_fix = 6;
        step();
        n_chk++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL rm_grant_pre got=%b exp=1000", grant); end
        step(); step();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rm_mem_req got=%b exp=0", mem_req); end
        n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rm_grant got=%b exp=0000", grant); end
        for (int j = 0; j < 2; j++) begin
            step();
            n_chk++; if ({ack, mem_req} !== 5'b0) begin n_fail++; $display("FAIL rm_in_reset got ack=%b mem_req=%b exp 0", ack, mem_req); end
        end
        reset = 1'b0;
        hold = '0;
        lat_fix = 0;
        step();
        n_chk++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rm_grant_after got=%b exp=0010", grant); end
        for (int j = 0; j < 6; j++) begin
            step();
            n_chk++; if (ack !== exp_ack) begin n_fail++; $display("FAIL rm_ack j=%0d got=%b exp=%b", j, ack, exp_ack); end
        end
    endtask

    task automatic test_random();
        int waited[N];
        lat_fix = -1;
        hold = '0;
        for (int i = 0; i < N; i++) waited[i] = 0;
        for (int j = 0; j < 400; j++) begin
            step();
            n_chk++; if (mem_req !== exp_mem_req) begin n_fail++; $display("FAIL rnd_mem_req cyc=%0d got=%b exp=%b", cyc, mem_req, exp_mem_req); end
            n_chk++; if (grant !== exp_grant) begin n_fail++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, grant, exp_grant); end
            n_chk++; if (ack !== exp_ack) begin n_fail++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, ack, exp_ack); end
            n_chk++; if (wait_n !== exp_wait_n) begin n_fail++; $display("FAIL rnd_wait_n cyc=%0d got=%b exp=%b", cyc, wait_n, exp_wait_n); end
            n_chk++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rdata, m_rdata); end
            n_chk++; if ({mem_we, mem_addr, mem_wdata} !== {m_we, m_addr, m_wd}) begin
                n_fail++; $display("FAIL rnd_mem_bus cyc=%0d got we=%b a=%h d=%h exp we=%b a=%h d=%h",
                                   cyc, mem_we, mem_addr, mem_wdata, m_we, m_addr, m_wd);
            end
            for (int i = 0; i < N; i++) begin
                if (req[i]) waited[i]++;
                if (exp_ack[i]) begin
                    n_chk++; if (waited[i] > 26) begin n_fail++; $display("FAIL rnd_starve core=%0d waited=%0d max=26", i, waited[i]); end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    addr[i*AW +: AW]  = 16'($urandom);
                    wdata[i*DW +: DW] = 8'($urandom);
                    wr[i]  = 1'($urandom_range(0, 1));
                    req[i] = 1'b1;
                    waited[i] = 0;
                end
            end
        end
        req = '0;
        repeat (8) step();
    endtask

    initial begin
        reset = 1'b1;
        req = '0; wr = '0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        model_reset();
        test_reset();
        test_single_read();
        test_all_four();
        test_delayed_write();
        test_rr_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
